// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding and width defaults for the iterative square root engine
package sqrt_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ROOT_W_DEF = DATA_W_DEF / 2;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  function automatic int cnt_w(input int rw);
    return rw > 1 ? $clog2(rw) : 1;
  endfunction
endpackage

// File: rtl/sqrt_rem_step.sv
// sqrt_rem_step: one non-restoring root digit (ports r, q, pair in; r_next, digit out)
module sqrt_rem_step import sqrt_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROOT_W = DATA_W / 2
) (
  input  logic [DATA_W-1:0] r,
  input  logic [ROOT_W-1:0] q,
  input  logic [1:0]        pair,
  output logic [DATA_W-1:0] r_next,
  output logic              digit
);
  logic [DATA_W-1:0] rs;
  always_comb begin
    rs = {r[DATA_W-3:0], pair};
    r_next = r[DATA_W-1] ? rs + DATA_W'({q, 2'b11}) : rs - DATA_W'({q, 2'b01});
    digit = ~r_next[DATA_W-1];
  end
endmodule

// File: rtl/sqrt_iter_engine.sv
// sqrt_iter_engine: valid/ready integer sqrt (radicand in; root, remainder, busy out; one digit per clock)
module sqrt_iter_engine import sqrt_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      radicand,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W/2-1:0]    root,
  output logic [DATA_W-1:0]      remainder,
  output logic                   busy
);
  localparam int ROOT_W = DATA_W / 2;
  localparam int CNT_W = cnt_w(ROOT_W);
  state_t state_q, state_d;
  logic [DATA_W-1:0] r_q, r_d, d_q, d_d, r_step;
  logic [ROOT_W-1:0] q_q, q_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic digit;
  // d_q shifts left each iteration so the current bit pair is always its top two bits
  sqrt_rem_step #(.DATA_W(DATA_W), .ROOT_W(ROOT_W)) u_step (
    .r(r_q), .q(q_q), .pair(d_q[DATA_W-1 -: 2]), .r_next(r_step), .digit(digit)
  );
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    i_d = i_q;
    case (state_q)
      IDLE: if (in_valid) begin
        d_d = radicand;
        r_d = '0;
        q_d = '0;
        i_d = CNT_W'(ROOT_W - 1);
        state_d = ITER;
      end
      ITER: begin
        r_d = r_step;
        q_d = {q_q[ROOT_W-2:0], digit};
        d_d = d_q << 2;
        i_d = i_q - CNT_W'(1);
        state_d = i_q == '0 ? FIX : ITER;
      end
      FIX: begin
        r_d = r_q[DATA_W-1] ? r_q + DATA_W'({q_q, 1'b1}) : r_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      i_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      i_q <= i_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == ITER || state_q == FIX;
  assign root = q_q;
  assign remainder = r_q;
endmodule

// File: tb/tb_sqrt_iter_engine.sv
// tb_sqrt_iter_engine: directed and model-checked bench for sqrt_iter_engine
module tb_sqrt_iter_engine;
  import sqrt_pkg::*;
  localparam int DW = DATA_W_DEF;
  localparam int RW = ROOT_W_DEF;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [DW-1:0] radicand = '0;
  logic in_ready, out_valid, busy;
  logic [RW-1:0] root;
  logic [DW-1:0] remainder;
  int n_chk = 0, n_fail = 0;
  sqrt_iter_engine #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .radicand(radicand), .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .remainder(remainder), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] x);
    logic [RW-1:0] r, t;
    r = '0;
    for (int b = RW - 1; b >= 0; b--) begin
      t = r | (RW'(1) << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask
  task automatic do_op(input logic [DW-1:0] x, output logic [RW-1:0] r, output logic [DW-1:0] m, output int lat);
    in_valid = 1;
    radicand = x;
    @(posedge clk); #1;
    in_valid = 0;
    wait_valid(lat);
    r = root;
    m = remainder;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || root !== '0 || remainder !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b root=%0d rem=%0d, want 1 0 0 0 0", in_ready, out_valid, busy, root, remainder);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    logic [DW-1:0] xs [6] = '{32'd0, 32'd1, 32'd2, 32'd24, 32'd1000000, 32'hFFFFFFFF};
    logic [RW-1:0] er [6] = '{16'd0, 16'd1, 16'd1, 16'd4, 16'd1000, 16'd65535};
    logic [DW-1:0] em [6] = '{32'd0, 32'd0, 32'd1, 32'd8, 32'd0, 32'd131070};
    logic [RW-1:0] r;
    logic [DW-1:0] m;
    int lat;
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      do_op(xs[k], r, m, lat);
      n_chk++;
      if (r !== er[k] || m !== em[k]) begin
        n_fail++;
        $display("FAIL basic x=%0d: got %0d/%0d, want %0d/%0d", xs[k], r, m, er[k], em[k]);
      end
      n_chk++;
      if (lat !== 17) begin
        n_fail++;
        $display("FAIL latency x=%0d: got %0d, want 17", xs[k], lat);
      end
    end
  endtask
  task automatic test_backpressure();
    int lat;
    out_ready = 0;
    in_valid = 1;
    radicand = 144;
    @(posedge clk); #1;
    in_valid = 0;
    wait_valid(lat);
    n_chk++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d, want 17", lat);
    end
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      radicand = 9;
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || root !== 16'd12 || remainder !== 32'd0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: out_valid=%b root=%0d rem=%0d in_ready=%b, want 1 12 0 0", k, out_valid, root, remainder, in_ready);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask
  task automatic test_back_to_back();
    int lat;
    out_ready = 1;
    in_valid = 1;
    radicand = 49;
    @(posedge clk); #1;
    wait_valid(lat);
    n_chk++;
    if (lat !== 17 || root !== 16'd7 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d root=%0d rem=%0d, want 17 7 0", lat, root, remainder);
    end
    radicand = 50;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 0;
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    wait_valid(lat);
    n_chk++;
    if (lat !== 17 || root !== 16'd7 || remainder !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d root=%0d rem=%0d, want 17 7 1", lat, root, remainder);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    logic [RW-1:0] r;
    logic [DW-1:0] m;
    int lat;
    in_valid = 1;
    radicand = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || root !== 16'h001F) begin
      n_fail++;
      $display("FAIL mid_state: busy=%b root=%0h, want 1 1f", busy, root);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || root !== '0 || remainder !== '0) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b root=%0d rem=%0d, want 1 0 0 0 0", in_ready, out_valid, busy, root, remainder);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    do_op(81, r, m, lat);
    n_chk++;
    if (r !== 16'd9 || m !== 32'd0 || lat !== 17) begin
      n_fail++;
      $display("FAIL after_reset: got %0d/%0d lat %0d, want 9/0 lat 17", r, m, lat);
    end
  endtask
  task automatic test_random();
    logic [DW-1:0] x, m, e2;
    logic [RW-1:0] r, e;
    int lat;
    logic [15:0] k;
    for (int n = 0; n < 2000; n++) begin
      k = 16'($urandom);
      case ($urandom_range(0, 3))
        0: x = DW'(k) * DW'(k);
        1: x = DW'(k) * DW'(k) - 1;
        default: x = $urandom;
      endcase
      do_op(x, r, m, lat);
      e = isqrt(x);
      e2 = DW'(e) * DW'(e);
      n_chk++;
      if (r !== e || m !== x - e2 || lat !== 17) begin
        n_fail++;
        $display("FAIL random x=%0h: got %0d/%0d lat %0d, want %0d/%0d lat 17", x, r, m, lat, e, x - e2);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
